// File: rtl/alu_defs.sv
// Shared ALU definitions: control codes from the ALU controller and the
// state encoding of the sequential multiplier.
package alu_defs;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SLTIU = 4'b0011;
   localparam logic [3:0] ALU_SLT   = 4'b0100;
   localparam logic [3:0] ALU_MUL   = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_BEQ   = 4'b0111;
   localparam logic [3:0] ALU_SRA   = 4'b1000;
   localparam logic [3:0] ALU_SRAV  = 4'b1001;
   localparam logic [3:0] ALU_BNE   = 4'b1010;
   localparam logic [3:0] ALU_LUI   = 4'b1011;
   localparam logic [3:0] ALU_SGT   = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add signed multiplier: multiplies operand magnitudes over
// WIDTH cycles, then applies the sign to the full 2*WIDTH-bit product.
module alu_mul_seq
   import alu_defs::*;
#(
   parameter int         WIDTH    = 32,
   parameter logic [3:0] MUL_CODE = ALU_MUL
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [3:0]       ALUCtrl_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int CNT_W = $clog2(WIDTH);

   mul_state_t         state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               accept;
   logic [WIDTH-1:0]   abs1, abs2;
   logic [2*WIDTH-1:0] sum, product;

   // Magnitude of the most negative value is still representable unsigned.
   assign abs1    = src1_i[WIDTH-1] ? -src1_i : src1_i;
   assign abs2    = src2_i[WIDTH-1] ? -src2_i : src2_i;
   assign accept  = start_i && (ALUCtrl_i == MUL_CODE) &&
                    ((state_q == IDLE) || (state_q == DONE));
   assign sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product = neg_q ? -sum : sum;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      hi_d     = hi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         RUN: begin
            acc_d    = sum;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d          = DONE;
               busy_d           = 1'b0;
               done_d           = 1'b1;
               {hi_d, result_d} = product;
            end
         end
         DONE:    state_d = IDLE;
         IDLE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Accept from IDLE or straight out of DONE for back-to-back multiplies.
      if (accept) begin
         state_d  = RUN;
         mcand_d  = {{WIDTH{1'b0}}, abs1};
         mplier_d = abs2;
         neg_d    = src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         hi_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign result_o = result_q;
   assign hi_o     = hi_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative 32-cycle shift-add signed multiplier in the execute stage, directly downstream of the ALU controller.
- Consumes the 4-bit ALU control code plus both register operands and returns the 64-bit product.
- Raises busy_o so the pipeline control stalls PC/IF while a mul is in flight.
- Non-mul codes are handled by the combinational ALU; this block ignores them.

Parameters:
- WIDTH, 32: operand width. Product is 2*WIDTH.
- MUL_CODE, 4'b0101: ALU control code that selects multiply.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- ALUCtrl_i  input  4  ALU control code from the ALU controller.
- start_i  input  1  one-cycle request from execute-stage control.
- src1_i  input  WIDTH  multiplicand (rs), two's complement.
- src2_i  input  WIDTH  multiplier (rt), two's complement.
- result_o  output  WIDTH  low half of product, to writeback mux.
- hi_o  output  WIDTH  high half of product.
- busy_o  output  1  high while iterating; stall request.
- done_o  output  1  one-cycle pulse; result_o/hi_o are valid.

Behaviour:
- Reset (rst_i=0, async): state=IDLE; result_o=0, hi_o=0, busy_o=0, done_o=0; counter=0; accumulator=0.
- States: IDLE, RUN, DONE.
- Accept condition: start_i=1 and ALUCtrl_i==MUL_CODE, while the state is IDLE or DONE.
  - start_i with any other code is ignored and the state is unchanged.
- On accept:
  - Latch |src1_i| and |src2_i| as unsigned WIDTH-bit magnitudes.
  - Latch neg = src1_i[MSB] ^ src2_i[MSB].
  - Clear the 2*WIDTH accumulator, counter=0, go to RUN, busy_o=1 from the next cycle.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). It fits unsigned WIDTH bits; no overflow special-case.
- RUN, each cycle:
  - If multiplier LSB=1, add the shifted multiplicand into the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; counter+1.
  - Use a 2*WIDTH-bit adder; no carry lost.
- RUN exit: after exactly WIDTH iterations (counter==WIDTH-1 at the last one), go to DONE.
  - No early termination on zero operands; latency is fixed.
- Entering DONE:
  - {hi_o,result_o} = neg ? two's-complement negate(accumulator) : accumulator.
  - busy_o=0, done_o=1 for exactly one cycle.
- DONE: next cycle returns to IDLE unless an accept occurs, which goes straight to RUN (back-to-back).
- Outputs hold their last product until the next DONE entry or reset. They are not cleared on accept.
- Latency: accept on edge N; busy_o high on cycles N+1..N+WIDTH; done_o high on cycle N+WIDTH+1.
- start_i during RUN is ignored. No queuing; upstream must be stalled by busy_o.
- ALUCtrl_i/src*_i changes during RUN have no effect, since operands are latched.
- Reset asserted mid-RUN aborts immediately. No done_o pulse; outputs return to 0.
- Result is the full signed 64-bit product. The pipeline uses result_o for mul; hi_o is reserved for mfhi.

Decomposition:
- Shared package alu_defs holds:
  - ALU control code constants: AND=0000, OR=0001, ADD=0010, SLTIU=0011, SLT=0100, MUL=0101, SUB=0110, BEQ=0111, SRA=1000, SRAV=1001, BNE=1010, LUI=1011, SGT=1100.
  - The 2-bit state encoding IDLE=00, RUN=01, DONE=10.
  - The ALU controller and this block both reference it.
- No sub-module. Datapath, counter and FSM are small enough to stay in one module.

Test Plan:
- Reset, then start_i=1 with ALUCtrl_i=0101, src1=7, src2=6 -> busy_o high 32 cycles; done_o pulse on cycle 33 after accept; result_o=42, hi_o=0.
- src1=-3 (0xFFFFFFFD), src2=5 -> result_o=0xFFFFFFF1, hi_o=0xFFFFFFFF. Then src1=0x80000000, src2=0x80000000 -> hi_o=0x40000000, result_o=0.
- start_i=1 with ALUCtrl_i=0010 (add), src1=9, src2=9 -> state stays IDLE; busy_o=0, done_o=0; outputs unchanged.
- During RUN of 0x0000FFFF*0x0000FFFF, pulse start_i with new operands 1*1 -> ignored; result_o=0xFFFE0001, hi_o=0.
- Back-to-back: start in the DONE cycle with 2*3 right after 4*5 -> first done gives 20, second done 33 cycles later gives 6; busy_o low only during the DONE cycle.
- Drop rst_i at RUN cycle 10 -> busy_o, done_o, result_o, hi_o go 0 asynchronously. After release, a new 1*-1 gives 0xFFFFFFFF / 0xFFFFFFFF.
